// File: rtl/zii_ide_ctrl.sv
// zii_ide_ctrl -- Zorro II IDE / boot-ROM cycle controller.
//
// Decodes CPU cycles that hit the 64 KB window at BASE_IDE (once AutoConfig
// has configured the board) and runs a counter-timed PIO sequence:
//   A[15]=1 : IDE task file (A[12]=0 -> CS0, A[12]=1 -> CS1), IDE_A = A[4:2]
//   A[15]=0 : boot ROM, only when JP7=1
//
// Ports:
//   C7M, RESET_n         clock (rising edge) / async active-low reset
//   AS_CPU_n, DS_n, RW_n CPU bus strobes and direction (bus-synchronous)
//   A[23:1]              CPU address
//   BASE_IDE, IDE_CONFIGURED_n  board base A[23:16] and its valid flag
//   JP7                  boot ROM enable jumper
//   IDE_CS0_n/CS1_n, IDE_A, IDE_IOR_n, IDE_IOW_n   IDE interface
//   ROM_OE_n, BUF_OE_n, BUF_DIR                    ROM and data buffer control
//   DTACK_n              cycle acknowledge to the bus
//   o_dbg_state          current sequencer state (IDLE=0, SETUP=1, STROBE=2,
//                        ACK=3, ROM=4, RECOVER=5)
//
// Handshake: a bus cycle is requested while AS_CPU_n and DS_n are low; DTACK_n
// is held low until AS_CPU_n is sampled high, which ends the cycle. AS_CPU_n
// sampled high before DTACK_n aborts the cycle without acknowledging it.
// Every output is a flop, so reset forces outputs immediately.
module zii_ide_ctrl #(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 3,
  parameter int RECOVERY_CYC = 2,
  parameter int ROM_WAIT     = 2
) (
  input  logic        C7M,
  input  logic        RESET_n,
  input  logic        AS_CPU_n,
  input  logic        DS_n,
  input  logic        RW_n,
  input  logic [23:1] A,
  input  logic [7:0]  BASE_IDE,
  input  logic        IDE_CONFIGURED_n,
  input  logic        JP7,
  output logic        IDE_CS0_n,
  output logic        IDE_CS1_n,
  output logic [2:0]  IDE_A,
  output logic        IDE_IOR_n,
  output logic        IDE_IOW_n,
  output logic        ROM_OE_n,
  output logic        BUF_OE_n,
  output logic        BUF_DIR,
  output logic        DTACK_n,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    ACK     = 3'd3,
    ROM     = 3'd4,
    RECOVER = 3'd5
  } state_t;

  state_t      r_state, w_state_nx;
  logic [2:0]  r_cnt, w_cnt_nx;
  logic        r_rw_n, w_rw_n_nx;
  logic        r_cs0_n, w_cs0_n_nx;
  logic        r_cs1_n, w_cs1_n_nx;
  logic [2:0]  r_ide_a, w_ide_a_nx;
  logic        r_ior_n, w_ior_n_nx;
  logic        r_iow_n, w_iow_n_nx;
  logic        r_rom_oe_n, w_rom_oe_n_nx;
  logic        r_buf_oe_n, w_buf_oe_n_nx;
  logic        r_buf_dir, w_buf_dir_nx;
  logic        r_dtack_n, w_dtack_n_nx;
  logic        w_hit;

  assign w_hit = !IDE_CONFIGURED_n && (A[23:16] == BASE_IDE) && !AS_CPU_n && !DS_n;

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_rw_n_nx     = r_rw_n;
    w_cs0_n_nx    = r_cs0_n;
    w_cs1_n_nx    = r_cs1_n;
    w_ide_a_nx    = r_ide_a;
    w_ior_n_nx    = r_ior_n;
    w_iow_n_nx    = r_iow_n;
    w_rom_oe_n_nx = r_rom_oe_n;
    w_buf_oe_n_nx = r_buf_oe_n;
    w_buf_dir_nx  = r_buf_dir;
    w_dtack_n_nx  = r_dtack_n;

    case (r_state)
      IDLE: begin
        if (w_hit && A[15]) begin
          // Address and direction are captured here and held for the cycle.
          w_state_nx    = SETUP;
          w_cs0_n_nx    = A[12];
          w_cs1_n_nx    = !A[12];
          w_ide_a_nx    = A[4:2];
          w_rw_n_nx     = RW_n;
          w_buf_dir_nx  = RW_n;
          w_buf_oe_n_nx = 1'b0;
          w_cnt_nx      = 3'(SETUP_CYC - 1);
        end else if (w_hit && !A[15] && JP7) begin
          w_state_nx    = ROM;
          w_rom_oe_n_nx = 1'b0;
          w_buf_dir_nx  = 1'b1;
          w_buf_oe_n_nx = 1'b0;
          w_cnt_nx      = 3'(ROM_WAIT - 1);
        end
      end
      SETUP: begin
        if (AS_CPU_n) begin
          w_state_nx = RECOVER;
        end else if (r_cnt == 3'd0) begin
          w_state_nx = STROBE;
          w_ior_n_nx = !r_rw_n;
          w_iow_n_nx = r_rw_n;
          w_cnt_nx   = 3'(STROBE_CYC - 1);
        end else begin
          w_cnt_nx = r_cnt - 3'd1;
        end
      end
      STROBE: begin
        if (AS_CPU_n) begin
          w_state_nx = RECOVER;
        end else if (r_cnt == 3'd0) begin
          // Write strobe ends here; read strobe stays low to hold data.
          w_state_nx   = ACK;
          w_dtack_n_nx = 1'b0;
          w_iow_n_nx   = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - 3'd1;
        end
      end
      ACK: begin
        if (AS_CPU_n) w_state_nx = RECOVER;
      end
      ROM: begin
        if (AS_CPU_n) begin
          w_state_nx = RECOVER;
        end else if (r_cnt == 3'd0) begin
          w_dtack_n_nx = 1'b0;
        end else begin
          w_cnt_nx = r_cnt - 3'd1;
        end
      end
      RECOVER: begin
        if (r_cnt == 3'd0) w_state_nx = IDLE;
        else               w_cnt_nx   = r_cnt - 3'd1;
      end
      default: w_state_nx = IDLE;
    endcase

    // Every entry into RECOVER releases the bus and starts the recovery count.
    if (w_state_nx == RECOVER && r_state != RECOVER) begin
      w_cnt_nx      = 3'(RECOVERY_CYC - 1);
      w_cs0_n_nx    = 1'b1;
      w_cs1_n_nx    = 1'b1;
      w_ior_n_nx    = 1'b1;
      w_iow_n_nx    = 1'b1;
      w_rom_oe_n_nx = 1'b1;
      w_buf_oe_n_nx = 1'b1;
      w_dtack_n_nx  = 1'b1;
    end
  end

  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_rw_n     <= 1'b1;
      r_cs0_n    <= 1'b1;
      r_cs1_n    <= 1'b1;
      r_ide_a    <= 3'd0;
      r_ior_n    <= 1'b1;
      r_iow_n    <= 1'b1;
      r_rom_oe_n <= 1'b1;
      r_buf_oe_n <= 1'b1;
      r_buf_dir  <= 1'b0;
      r_dtack_n  <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_rw_n     <= w_rw_n_nx;
      r_cs0_n    <= w_cs0_n_nx;
      r_cs1_n    <= w_cs1_n_nx;
      r_ide_a    <= w_ide_a_nx;
      r_ior_n    <= w_ior_n_nx;
      r_iow_n    <= w_iow_n_nx;
      r_rom_oe_n <= w_rom_oe_n_nx;
      r_buf_oe_n <= w_buf_oe_n_nx;
      r_buf_dir  <= w_buf_dir_nx;
      r_dtack_n  <= w_dtack_n_nx;
    end
  end

  assign IDE_CS0_n   = r_cs0_n;
  assign IDE_CS1_n   = r_cs1_n;
  assign IDE_A       = r_ide_a;
  assign IDE_IOR_n   = r_ior_n;
  assign IDE_IOW_n   = r_iow_n;
  assign ROM_OE_n    = r_rom_oe_n;
  assign BUF_OE_n    = r_buf_oe_n;
  assign BUF_DIR     = r_buf_dir;
  assign DTACK_n     = r_dtack_n;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_zii_ide_ctrl.sv
// Directed bench for zii_ide_ctrl: table of single bus accesses plus
// hand-written sequences for back-to-back recovery, abort and async reset.
module tb_zii_ide_ctrl;

  localparam int ST_IDLE    = 0;
  localparam int ST_RECOVER = 5;

  logic        C7M = 1'b0;
  logic        RESET_n;
  logic        AS_CPU_n, DS_n, RW_n;
  logic [23:1] A;
  logic [7:0]  BASE_IDE;
  logic        IDE_CONFIGURED_n, JP7;
  logic        IDE_CS0_n, IDE_CS1_n;
  logic [2:0]  IDE_A;
  logic        IDE_IOR_n, IDE_IOW_n, ROM_OE_n, BUF_OE_n, BUF_DIR, DTACK_n;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset block
  always #5 C7M = ~C7M;

  zii_ide_ctrl dut (
    .C7M(C7M), .RESET_n(RESET_n), .AS_CPU_n(AS_CPU_n), .DS_n(DS_n), .RW_n(RW_n),
    .A(A), .BASE_IDE(BASE_IDE), .IDE_CONFIGURED_n(IDE_CONFIGURED_n), .JP7(JP7),
    .IDE_CS0_n(IDE_CS0_n), .IDE_CS1_n(IDE_CS1_n), .IDE_A(IDE_A),
    .IDE_IOR_n(IDE_IOR_n), .IDE_IOW_n(IDE_IOW_n), .ROM_OE_n(ROM_OE_n),
    .BUF_OE_n(BUF_OE_n), .BUF_DIR(BUF_DIR), .DTACK_n(DTACK_n),
    .o_dbg_state(dbg_state)
  );

  typedef struct {
    string       name;
    logic [23:0] addr;
    logic        rw_n;
    logic        jp7;
    logic        cfg_n;
    logic [7:0]  base;
    logic        exp_cs0_n;
    logic        exp_cs1_n;
    logic        chk_a;
    logic [2:0]  exp_a;
    logic        chk_dir;
    logic        exp_dir;
    logic        exp_rom_oe_n;
    logic        exp_buf_oe_n;
    int          exp_dtack;   // edge index of first DTACK low, -1 = never
    int          exp_ior;     // samples with IOR_n low while AS held
    int          exp_iow;
  } vec_t;

  vec_t vecs[9];

  // scoreboard check
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    AS_CPU_n = 1'b1;
    DS_n     = 1'b1;
  endtask

  task automatic start_access(input logic [23:0] addr, input logic rw_n);
    A        = addr[23:1];
    RW_n     = rw_n;
    AS_CPU_n = 1'b0;
    DS_n     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int ior_cnt, iow_cnt, dtack_at;
    @(negedge C7M);
    BASE_IDE = v.base;
    IDE_CONFIGURED_n = v.cfg_n;
    JP7 = v.jp7;
    start_access(v.addr, v.rw_n);
    @(posedge C7M); #1;  // edge 0
    check({v.name, " cs0_n"}, int'(IDE_CS0_n), int'(v.exp_cs0_n));
    check({v.name, " cs1_n"}, int'(IDE_CS1_n), int'(v.exp_cs1_n));
    check({v.name, " rom_oe_n"}, int'(ROM_OE_n), int'(v.exp_rom_oe_n));
    check({v.name, " buf_oe_n"}, int'(BUF_OE_n), int'(v.exp_buf_oe_n));
    if (v.chk_a)   check({v.name, " ide_a"}, int'(IDE_A), int'(v.exp_a));
    if (v.chk_dir) check({v.name, " buf_dir"}, int'(BUF_DIR), int'(v.exp_dir));
    ior_cnt  = 0;
    iow_cnt  = 0;
    dtack_at = -1;
    for (int e = 1; e <= 20 && dtack_at < 0; e++) begin
      @(posedge C7M); #1;
      if (!IDE_IOR_n) ior_cnt++;
      if (!IDE_IOW_n) iow_cnt++;
      if (!DTACK_n) dtack_at = e;
    end
    if (dtack_at >= 0) begin
      // AS held one cycle past DTACK
      @(posedge C7M); #1;
      if (!IDE_IOR_n) ior_cnt++;
      if (!IDE_IOW_n) iow_cnt++;
    end
    check({v.name, " dtack edge"}, dtack_at, v.exp_dtack);
    @(negedge C7M);
    idle_bus();
    @(posedge C7M); #1;
    check({v.name, " released"},
          int'({IDE_CS0_n, IDE_CS1_n, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, BUF_OE_n, DTACK_n}),
          7'h7f);
    check({v.name, " ior cycles"}, ior_cnt, v.exp_ior);
    check({v.name, " iow cycles"}, iow_cnt, v.exp_iow);
    repeat (4) @(posedge C7M);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dt_low, ior_low;

    //                 name        addr       rw jp7 cfg base   cs0 cs1 chkA A    chkD dir rom boe dtk ior iow
    vecs[0] = '{"unconfig",  24'hE98000, 1, 1, 1, 8'hE9, 1, 1, 0, 3'd0, 1, 0, 1, 1, -1, 0, 0};
    vecs[1] = '{"ide_rd_cs0",24'hE98010, 1, 1, 0, 8'hE9, 0, 1, 1, 3'd4, 1, 1, 1, 0,  4, 5, 0};
    vecs[2] = '{"ide_wr_cs1",24'hE99018, 0, 1, 0, 8'hE9, 1, 0, 1, 3'd6, 1, 0, 1, 0,  4, 0, 3};
    vecs[3] = '{"rom_jp7",   24'hE90010, 1, 1, 0, 8'hE9, 1, 1, 0, 3'd0, 1, 1, 0, 0,  2, 0, 0};
    vecs[4] = '{"rom_nojp7", 24'hE90010, 1, 0, 0, 8'hE9, 1, 1, 0, 3'd0, 0, 0, 1, 1, -1, 0, 0};
    vecs[5] = '{"wrong_base",24'hEA8010, 1, 1, 0, 8'hE9, 1, 1, 0, 3'd0, 0, 0, 1, 1, -1, 0, 0};
    vecs[6] = '{"ide_rd_cs1",24'hE9F01C, 1, 1, 0, 8'hE9, 1, 0, 1, 3'd7, 1, 1, 1, 0,  4, 5, 0};
    vecs[7] = '{"ide_wr_cs0",24'hE98004, 0, 1, 0, 8'hE9, 0, 1, 1, 3'd1, 1, 0, 1, 0,  4, 0, 3};
    vecs[8] = '{"new_base",  24'h208008, 1, 1, 0, 8'h20, 0, 1, 1, 3'd2, 1, 1, 1, 0,  4, 5, 0};

    RESET_n = 1'b0;
    idle_bus();
    RW_n = 1'b1;
    A = '0;
    BASE_IDE = 8'hE9;
    IDE_CONFIGURED_n = 1'b1;
    JP7 = 1'b1;
    #12;
    check("reset outputs",
          int'({IDE_CS0_n, IDE_CS1_n, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, BUF_OE_n, DTACK_n}), 7'h7f);
    check("reset ide_a", int'(IDE_A), 0);
    check("reset buf_dir", int'(BUF_DIR), 0);
    @(negedge C7M);
    RESET_n = 1'b1;
    @(posedge C7M); #1;
    check("reset state", int'(dbg_state), ST_IDLE);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // back-to-back: a new AS right after release waits out recovery
    @(negedge C7M);
    BASE_IDE = 8'hE9;
    IDE_CONFIGURED_n = 1'b0;
    start_access(24'hE98010, 1'b1);
    dt_low = 0;
    for (int e = 0; e < 20 && !dt_low; e++) begin
      @(posedge C7M); #1;
      if (!DTACK_n) dt_low = 1;
    end
    check("b2b dtack seen", dt_low, 1);
    @(negedge C7M);
    idle_bus();
    @(posedge C7M); #1;
    check("b2b cs released", int'(IDE_CS0_n), 1);
    @(negedge C7M);
    start_access(24'hE98010, 1'b1);
    @(posedge C7M); #1;
    check("b2b rec1 cs0_n", int'(IDE_CS0_n), 1);
    @(posedge C7M); #1;
    check("b2b rec2 cs0_n", int'(IDE_CS0_n), 1);
    @(posedge C7M); #1;
    check("b2b accept cs0_n", int'(IDE_CS0_n), 0);
    @(negedge C7M);
    idle_bus();
    repeat (6) @(posedge C7M);

    // abort: AS rises during SETUP
    @(negedge C7M);
    start_access(24'hE98010, 1'b1);
    @(posedge C7M); #1;
    check("abort setup cs0_n", int'(IDE_CS0_n), 0);
    @(negedge C7M);
    idle_bus();
    @(posedge C7M); #1;
    check("abort cs released", int'(IDE_CS0_n), 1);
    check("abort state", int'(dbg_state), ST_RECOVER);
    dt_low = 0;
    ior_low = 0;
    if (!DTACK_n) dt_low++;
    if (!IDE_IOR_n) ior_low++;
    for (int e = 0; e < 5; e++) begin
      @(posedge C7M); #1;
      if (!DTACK_n) dt_low++;
      if (!IDE_IOR_n) ior_low++;
    end
    check("abort dtack cycles", dt_low, 0);
    check("abort ior cycles", ior_low, 0);
    check("abort final state", int'(dbg_state), ST_IDLE);

    // asynchronous reset in the middle of STROBE
    @(negedge C7M);
    start_access(24'hE98010, 1'b1);
    repeat (3) @(posedge C7M);
    #1;
    check("pre-reset ior_n", int'(IDE_IOR_n), 0);
    #2;
    RESET_n = 1'b0;
    #1;
    check("async reset outputs",
          int'({IDE_CS0_n, IDE_CS1_n, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, BUF_OE_n, DTACK_n}), 7'h7f);
    check("async reset ide_a", int'(IDE_A), 0);
    idle_bus();
    @(negedge C7M);
    RESET_n = 1'b1;
    dt_low = 0;
    for (int e = 0; e < 5; e++) begin
      @(posedge C7M); #1;
      if (!DTACK_n) dt_low++;
    end
    check("post-reset dtack cycles", dt_low, 0);
    check("post-reset state", int'(dbg_state), ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
